// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the program sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

  // Default program-counter width: instruction memory holds 2^FETCH_D words.
  localparam int unsigned FETCH_D = 9;

  // Default number of return-address stack entries.
  localparam int unsigned FETCH_RAS_DEPTH = 4;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/ret_stack.sv
// Circular return-address stack; exists only when FETCH_CTRL_RAS_EN is defined.
// Latency: push/pop take effect at the next edge; top_addr is read combinationally.
// Backpressure: none; overflow overwrites the oldest entry, underflow is a no-op, both set sticky err.
`ifdef FETCH_CTRL_RAS_EN
module ret_stack
  import fetch_pkg::*;
#(
  parameter int D     = FETCH_D,
  parameter int DEPTH = FETCH_RAS_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [D-1:0] push_addr,
  output logic [D-1:0] top_addr,
  output logic         empty,
  output logic         full,
  output logic         err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [D-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;       // next slot to write; when full it points at the oldest entry
  logic [CW-1:0] cnt;
  logic [PW-1:0] top_idx;
  logic [PW-1:0] wp_inc;

  // Circular pointer arithmetic, valid for any depth.
  always_comb begin
    top_idx = (wp == '0) ? LAST : wp - PW'(1);
    wp_inc  = (wp == LAST) ? '0 : wp + PW'(1);
  end

  assign top_addr = mem[top_idx];
  assign empty    = (cnt == '0);
  assign full     = (cnt == CNT_FULL);

  // Pointer, occupancy and sticky error; the count saturates so overflow keeps the newest DEPTH entries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp  <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else if (clear) begin
      wp  <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else if (push) begin
      wp <= wp_inc;
      if (full) err <= 1'b1;
      else      cnt <= cnt + CW'(1);
    end else if (pop) begin
      if (empty) begin
        err <= 1'b1;
      end else begin
        wp  <= top_idx;
        cnt <= cnt - CW'(1);
      end
    end
  end

  // Entry storage needs no reset; occupancy tracking decides what is live.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wp] <= push_addr;
  end

endmodule
`endif

// File: rtl/fetch_ctrl.sv
// Program sequencer owning the PC: start launch, stall, jumps, halt, optional call/return (FETCH_CTRL_RAS_EN).
// Latency: every decision sampled at an edge is visible on prog_ctr right after it; no bubbles.
// Backpressure: stall holds the PC and drops lower-priority events; start is only honoured in IDLE.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int D         = FETCH_D,
  parameter int RAS_DEPTH = FETCH_RAS_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [D-1:0] start_addr,
  input  logic         stall,
  input  logic         halt,
  input  logic         reljump_en,
  input  logic         absjump_en,
  input  logic         call_en,
  input  logic         ret_en,
  input  logic [D-1:0] target,
  output logic [D-1:0] prog_ctr,
  output logic         fetch_valid,
  output logic         busy,
  output logic         done,
  output logic         ras_err
);

  fetch_state_t state, state_next;
  logic [D-1:0] pc_next;
  logic [D-1:0] pc_inc;

  assign pc_inc = prog_ctr + D'(1);

`ifdef FETCH_CTRL_RAS_EN
  logic         stk_push;
  logic         stk_pop;
  logic         stk_clr;
  logic [D-1:0] stk_top;
  logic         stk_empty;
  logic         stk_full_unused;

  ret_stack #(.D(D), .DEPTH(RAS_DEPTH)) u_ret_stack (
    .clk       (clk),
    .reset     (reset),
    .clear     (stk_clr),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_addr (pc_inc),
    .top_addr  (stk_top),
    .empty     (stk_empty),
    .full      (stk_full_unused),
    .err       (ras_err)
  );
`else
  // Call/return are ignored in this build; keep the ports and depth parameter referenced.
  logic unused_ras;
  assign unused_ras = call_en ^ ret_en ^ (RAS_DEPTH == 0);
  assign ras_err    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: launch on start, leave RUN on halt, DONE lasts one cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (halt)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode the registered state only, so no input reaches an output combinationally.
  always_comb begin
    fetch_valid = (state == RUN);
    busy        = (state != IDLE);
    done        = (state == DONE);
  end

  // Next PC and stack controls; the if-chain order is the RUN priority order.
  always_comb begin
    pc_next = prog_ctr;
`ifdef FETCH_CTRL_RAS_EN
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    stk_clr  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          pc_next = start_addr;
`ifdef FETCH_CTRL_RAS_EN
          stk_clr = 1'b1;
`endif
        end
      end
      RUN: begin
        if (halt || stall) begin
          pc_next = prog_ctr;
`ifdef FETCH_CTRL_RAS_EN
        end else if (ret_en) begin
          stk_pop = 1'b1;
          pc_next = stk_empty ? pc_inc : stk_top;
        end else if (call_en) begin
          stk_push = 1'b1;
          pc_next  = target;
`endif
        end else if (absjump_en) begin
          pc_next = target;
        end else if (reljump_en) begin
          pc_next = prog_ctr + target;
        end else begin
          pc_next = pc_inc;
        end
      end
      default: pc_next = prog_ctr;
    endcase
  end

  // Program counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prog_ctr <= '0;
    else        prog_ctr <= pc_next;
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a queue-based reference model checked every cycle.
// Latency: model and DUT both update on the rising edge; comparisons happen on the falling edge.
// Backpressure: n/a.
module tb_fetch_ctrl;

  localparam int D  = 9;
  localparam int RD = 4;

  // Control vector bit masks for cyc(): {start, stall, halt, ret, call, abs, rel}.
  localparam logic [6:0] S  = 7'b1000000;
  localparam logic [6:0] ST = 7'b0100000;
  localparam logic [6:0] H  = 7'b0010000;
  localparam logic [6:0] R  = 7'b0001000;
  localparam logic [6:0] C  = 7'b0000100;
  localparam logic [6:0] A  = 7'b0000010;
  localparam logic [6:0] J  = 7'b0000001;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [D-1:0] start_addr = '0;
  logic         stall = 1'b0;
  logic         halt = 1'b0;
  logic         reljump_en = 1'b0;
  logic         absjump_en = 1'b0;
  logic         call_en = 1'b0;
  logic         ret_en = 1'b0;
  logic [D-1:0] target = '0;
  logic [D-1:0] prog_ctr;
  logic         fetch_valid;
  logic         busy;
  logic         done;
  logic         ras_err;

  int checks = 0;
  int errors = 0;

  fetch_ctrl #(.D(D), .RAS_DEPTH(RD)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .start_addr  (start_addr),
    .stall       (stall),
    .halt        (halt),
    .reljump_en  (reljump_en),
    .absjump_en  (absjump_en),
    .call_en     (call_en),
    .ret_en      (ret_en),
    .target      (target),
    .prog_ctr    (prog_ctr),
    .fetch_valid (fetch_valid),
    .busy        (busy),
    .done        (done),
    .ras_err     (ras_err)
  );

  always #5 clk = ~clk;

`ifdef FETCH_CTRL_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  // Reference model: running/finishing flags, PC, and a queue standing in for the stack.
  bit           m_running  = 1'b0;
  bit           m_finishing = 1'b0;
  logic [D-1:0] m_pc = '0;
  logic [D-1:0] m_stk[$];
  bit           m_err = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_running   = 1'b0;
      m_finishing = 1'b0;
      m_pc        = '0;
      m_stk.delete();
      m_err       = 1'b0;
    end else if (m_finishing) begin
      m_finishing = 1'b0;
    end else if (!m_running) begin
      if (start) begin
        m_running = 1'b1;
        m_pc      = start_addr;
        m_stk.delete();
        m_err     = 1'b0;
      end
    end else begin
      if (halt) begin
        m_running   = 1'b0;
        m_finishing = 1'b1;
      end else if (stall) begin
        m_pc = m_pc;
      end else if (RAS_ON && ret_en) begin
        if (m_stk.size() == 0) begin
          m_err = 1'b1;
          m_pc  = m_pc + 1;
        end else begin
          m_pc = m_stk.pop_back();
        end
      end else if (RAS_ON && call_en) begin
        m_stk.push_back(m_pc + 1);
        if (m_stk.size() > RD) begin
          void'(m_stk.pop_front());
          m_err = 1'b1;
        end
        m_pc = target;
      end else if (absjump_en) begin
        m_pc = target;
      end else if (reljump_en) begin
        m_pc = m_pc + target;
      end else begin
        m_pc = m_pc + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("prog_ctr", 16'(prog_ctr), 16'(m_pc));
    chk("fetch_valid", 16'(fetch_valid), 16'(m_running));
    chk("busy", 16'(busy), 16'(m_running || m_finishing));
    chk("done", 16'(done), 16'(m_finishing));
    chk("ras_err", 16'(ras_err), 16'(m_err));
  end

  // Drive one cycle of controls just after a rising edge, then return 1 time unit after the next one.
  task automatic cyc(input logic [6:0] ctl, input logic [D-1:0] tg);
    {start, stall, halt, ret_en, call_en, absjump_en, reljump_en} = ctl;
    target     = tg;
    start_addr = tg;
    @(posedge clk);
    #1;
    {start, stall, halt, ret_en, call_en, absjump_en, reljump_en} = '0;
  endtask

  initial begin
    #1;
    chk("rst_pc", 16'(prog_ctr), 16'h000);
    chk("rst_fv", 16'(fetch_valid), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_err", 16'(ras_err), 16'h0);
    #11 reset = 1'b1;
    @(posedge clk);
    #1;

    // Launch and sequential fetch.
    cyc(S, 9'h040);  chk("launch_pc", 16'(prog_ctr), 16'h040);
                     chk("launch_fv", 16'(fetch_valid), 16'h1);
    cyc('0, '0);     chk("inc1", 16'(prog_ctr), 16'h041);
    cyc('0, '0);     chk("inc2", 16'(prog_ctr), 16'h042);
    cyc(S, 9'h1AA);  chk("start_in_run", 16'(prog_ctr), 16'h043);

    // Stall blocks a jump, which is then forgotten.
    cyc(A, 9'h010);       chk("abs", 16'(prog_ctr), 16'h010);
    cyc(ST | A, 9'h100);  chk("stall_abs", 16'(prog_ctr), 16'h010);
    cyc(A, 9'h100);       chk("abs_after", 16'(prog_ctr), 16'h100);
    cyc(A | J, 9'h020);   chk("abs_over_rel", 16'(prog_ctr), 16'h020);

    // Relative and increment wrap.
    cyc(A, 9'h005);  cyc(J, 9'h1FB);  chk("rel_wrap", 16'(prog_ctr), 16'h000);
    cyc(J, 9'h010);  chk("rel_fwd", 16'(prog_ctr), 16'h010);
    cyc(A, 9'h1FF);  cyc('0, '0);     chk("inc_wrap", 16'(prog_ctr), 16'h000);

`ifdef FETCH_CTRL_RAS_EN
    cyc(A, 9'h030);
    cyc(C, 9'h080);  chk("call", 16'(prog_ctr), 16'h080);
    cyc(R, '0);      chk("ret", 16'(prog_ctr), 16'h031);
    cyc(C, 9'h100);  cyc(C, 9'h110);  cyc(C, 9'h120);  cyc(C, 9'h130);
    chk("four_calls_err", 16'(ras_err), 16'h0);
    cyc(C, 9'h140);  chk("overflow_err", 16'(ras_err), 16'h1);
    cyc(R, '0);      chk("ret1", 16'(prog_ctr), 16'h131);
    cyc(R, '0);      cyc(R, '0);
    cyc(R, '0);      chk("ret4", 16'(prog_ctr), 16'h101);
    cyc(R, '0);      chk("ret5_empty", 16'(prog_ctr), 16'h102);
    cyc(R, '0);      chk("ret6_empty", 16'(prog_ctr), 16'h103);
    cyc(R | C, 9'h050); chk("ret_over_call", 16'(prog_ctr), 16'h104);
`else
    cyc(A, 9'h030);
    cyc(C, 9'h080);  chk("call_ignored", 16'(prog_ctr), 16'h031);
    cyc(R | A, 9'h080); chk("ret_falls_to_abs", 16'(prog_ctr), 16'h080);
    cyc(R, '0);      chk("ret_ignored", 16'(prog_ctr), 16'h081);
    chk("err_tied", 16'(ras_err), 16'h0);
`endif

    // Halt handshake; start during DONE is ignored, next start launches.
    cyc(A, 9'h020);
    cyc(H | ST, '0);  chk("halt_done", 16'(done), 16'h1);
                      chk("halt_fv", 16'(fetch_valid), 16'h0);
                      chk("halt_pc", 16'(prog_ctr), 16'h020);
    cyc(S, 9'h060);   chk("done_gone", 16'(done), 16'h0);
                      chk("busy_fell", 16'(busy), 16'h0);
                      chk("pc_held", 16'(prog_ctr), 16'h020);
    cyc(S, 9'h060);   chk("relaunch", 16'(prog_ctr), 16'h060);
                      chk("relaunch_err", 16'(ras_err), 16'h0);

    // Asynchronous reset in the middle of a cycle.
    cyc(A, 9'h0AA);   chk("pre_reset", 16'(prog_ctr), 16'h0AA);
    #2 reset = 1'b0;
    #1;
    chk("arst_pc", 16'(prog_ctr), 16'h000);
    chk("arst_busy", 16'(busy), 16'h0);
    chk("arst_done", 16'(done), 16'h0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    cyc('0, '0);      chk("idle_after", 16'(busy), 16'h0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
